// File: rtl/coder_pkg.sv
// Shared definitions for the coder family: priority-mode selectors and the
// code-width helper used to size index outputs.
package coder_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  function automatic int code_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/coder_pick.sv
// Combinational masked priority search: highest set bit in fixed mode, or the
// first set bit at or after `start` (wrapping at N-1) in round-robin mode.
module coder_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  input  logic         rr,
  output logic [W-1:0] idx,
  output logic         any
);

  // Doubling the vector turns the wrapping search into a linear one.
  logic [2*N-1:0] dbl;
  assign dbl = {vec, vec};

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would infer a latch; blocking '=' is right for combinational logic.
    idx = '0;
    any = |vec;
    if (rr) begin
      // Descending scan: the last hit written is the lowest position >= start.
      for (int k = 2*N-1; k >= 0; k--) begin
        if (dbl[k] && (k >= int'(start))) begin
          idx = (k >= N) ? W'(k - N) : W'(k);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) idx = W'(i);
      end
    end
  end

endmodule

// File: rtl/priority_coder.sv
// Registered N-to-log2(N) priority encoder with latched requests and a
// valid/ready output stage; selection works only on the pending register.
module priority_coder
  import coder_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int MODE = MODE_FIXED,
  localparam int W    = code_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [W-1:0] out_code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending
);

  localparam logic [W-1:0] LAST  = W'(N - 1);
  localparam logic         RR_EN = (MODE == MODE_RR);

  logic [W-1:0] ptr;
  logic [W-1:0] start;
  logic [W-1:0] sel_idx;
  logic         sel_any;
  logic         load;
  logic [N-1:0] clr;

  // Wrap explicitly at N-1 so non-power-of-two N never searches phantom slots.
  assign start = (ptr == LAST) ? '0 : ptr + 1'b1;

  coder_pick #(.N(N), .W(W)) u_pick (
    .vec   (pending),
    .start (start),
    .rr    (RR_EN),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  // Depends on out_ready only through registered state being loaded next edge.
  assign load = (!out_valid || out_ready) && sel_any;
  assign clr  = load ? (N'(1) << sel_idx) : '0;

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      ptr       <= LAST;
    end else begin
      // Set wins over clear: a request arriving as its index is granted stays.
      pending <= (pending & ~clr) | req;
      if (load) begin
        out_code  <= sel_idx;
        out_valid <= 1'b1;
        ptr       <= sel_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/priority_coder.md
# priority_coder

Parameterised, registered N-to-log2(N) priority encoder with request latching and a valid/ready output handshake. It generalises the team's fixed 8-to-3 combinational coder in three ways: any input count, selectable fixed or round-robin priority, and retention of every request until it has been encoded and consumed. It sits between asynchronous-ish event sources (single-cycle request pulses) and a downstream consumer that accepts one index per handshake.

## Interface
- `N`, default 8: number of request inputs; legal range N >= 2, need not be a power of two.
- `MODE`, default 0: `MODE_FIXED` (0) means the highest pending index wins; `MODE_RR` (1) means round-robin.
- `W`, derived localparam: $clog2(N), the output code width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req`  in  N  request vector; each high bit sets its pending bit at the next edge.
- `out_code`  out  W  encoded index of the granted request.
- `out_valid`  out  1  `out_code` is valid.
- `out_ready`  in  1  consumer accepts `out_code` when `out_valid && out_ready`.
- `pending`  out  N  latched, not-yet-granted requests (observation/status).

## Operation
- Pending register update each edge: `pending <= (pending & ~clr) | req`.
  - `clr` is the one-hot of the index loaded this cycle.
  - Set wins over clear: a `req` bit arriving in the same cycle its index is granted stays pending and is granted again later.
  - Repeated requests on an already-pending bit merge into a single grant.
- Selection operates on the `pending` register only, never on raw `req`.
- Load condition: `load = (!out_valid || out_ready) && (|pending)`.
  - If `load` is true, `out_code` takes the selected index and `out_valid` goes to 1.
  - Else if `out_ready` is true, `out_valid` goes to 0.
  - Otherwise `out_code` and `out_valid` hold.
- Fixed mode: the highest set index of `pending` is selected.
- Round-robin mode:
  - The search starts at `ptr+1` (mod N), ascending, wrapping at N-1 to 0.
  - `ptr` updates to the loaded index on each `load`.
- Out-of-range codes (values of N..2^W-1) are never produced.
- Reset values:
  - `pending` = 0, `out_valid` = 0, `out_code` = 0.
  - `ptr` = N-1, so the first round-robin search begins at index 0.
- Reset mid-operation discards all pending requests and any unconsumed output; nothing is replayed.

## Timing
- Latency: `req` high in cycle t, then `pending` bit high in cycle t+1, then `out_valid`/`out_code` in cycle t+2 (2 cycles, with the output stage empty).
- Throughput: one code per cycle while `out_ready` = 1 and `pending` is non-zero.
- Backpressure: while `out_valid && !out_ready`, `out_code` is stable. New requests accumulate in `pending` and are not cleared.
- Handshake rules:
  - `out_valid` never deasserts without a completed transfer, except by reset.
  - `out_ready` may toggle freely.
  - There is no combinational path from `out_ready` to `out_valid`/`out_code`.
- Round-robin wrap: with `ptr` = N-1 the search starts at 0. For N not a power of two, the wrap happens at N-1, not at 2^W-1.
- `rst` is asynchronous: outputs take reset values immediately on assertion, independent of `clk`. Deassertion is synchronised externally.

## Structure
- Shared package `coder_pkg`:
  - `MODE_FIXED` / `MODE_RR` constants.
  - A `clog2`-based width helper, reused by the other coder-family blocks.
- One sub-module `coder_pick`: combinational masked priority search.
  - Inputs: vector, start index, mode.
  - Outputs: index and `any`.
  - Implemented as a double-width (vector concatenated with itself) lowest-set-bit search for round-robin, and a highest-set-bit search for fixed mode.
- The top level holds `pending`, `ptr`, and the output register/handshake only.

## Test plan
- Fixed, N=8:
  - Stimulus: one-cycle `req`=8'b1010_0000, `out_ready`=1.
  - Response: code 7 at t+2, then code 5 at t+3, `out_valid`=0 at t+4, `pending`=0.
- Backpressure:
  - Stimulus: `out_ready`=0, `req`=8'h01, later `req`=8'h04.
  - Response: `out_code`=0 held with `out_valid`=1 and `pending`=8'h04. On `out_ready`=1, code 2 the following cycle.
- Round-robin, N=8:
  - Stimulus: `req`=8'hFF held continuously, `out_ready`=1.
  - Response: codes 0,1,2,...,7,0,1 on consecutive cycles.
- Set-wins collision:
  - Stimulus: `req[3]` pulsed in the cycle index 3 is loaded.
  - Response: `pending[3]` stays 1 and code 3 is issued a second time.
- Async reset mid-stream:
  - Stimulus: assert `rst` between clock edges with `out_valid`=1 and `pending`=8'h30.
  - Response: `out_valid`=0 and `pending`=0 immediately. After release, round-robin restarts at index 0.
- Non-power-of-two, N=5, `MODE_RR` (W=3):
  - Stimulus: `req`=5'b10001 held.
  - Response: codes alternate 0,4,0,4, and codes 5-7 never appear.
